// File: rtl/kt_pc_pkg.sv
// Shared types and helpers for the KT program counter with return-address stack.
// Strobe priority decode and sign extension live here so every user agrees on them.
package kt_pc_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_RET,
      OP_CALL,
      OP_JABS,
      OP_JREL,
      OP_INC
   } pc_op_e;

   typedef struct packed {
      logic stall;
      logic ret;
      logic call;
      logic jabs;
      logic jrel;
   } pc_strb_t;

   // Fixed priority: stall > ret > call > jump_abs > jump_rel > increment.
   function automatic pc_op_e decode_op(input pc_strb_t s);
      if (s.stall)     return OP_HOLD;
      else if (s.ret)  return OP_RET;
      else if (s.call) return OP_CALL;
      else if (s.jabs) return OP_JABS;
      else if (s.jrel) return OP_JREL;
      else             return OP_INC;
   endfunction

   // Sign-extend the low w bits of v to 64 bits; callers truncate to what they need.
   function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned w);
      logic signed [63:0] t;
      t = $signed(v << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/kt_ras.sv
// Return-address LIFO. Push while full and pop while empty are dropped and
// reported as single-cycle ovf/unf pulses; entries are not reset.
module kt_ras #(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4,
   localparam int DEPTH_W  = $clog2(RAS_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [ADDR_W-1:0]  push_data_i,
   output logic [ADDR_W-1:0]  top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               ovf_o,
   output logic               unf_o
);

   localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem;
   logic [DEPTH_W-1:0]               depth_q;
   logic [IDX_W-1:0]                 wr_idx, rd_idx;
   logic                             do_push, do_pop;

   assign full_o  = (depth_q == DEPTH_W'(RAS_DEPTH));
   assign empty_o = (depth_q == '0);
   assign depth_o = depth_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign ovf_o   = push_i && full_o;
   assign unf_o   = pop_i && empty_o;

   assign wr_idx  = IDX_W'(depth_q);
   assign rd_idx  = IDX_W'(depth_q - DEPTH_W'(1));
   assign top_o   = empty_o ? '0 : mem[rd_idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        depth_q <= '0;
      else if (do_push) depth_q <= depth_q + DEPTH_W'(1);
      else if (do_pop)  depth_q <= depth_q - DEPTH_W'(1);
   end

   // Gate on reset so an edge coinciding with reset leaves no half-done push.
   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) mem[wr_idx] <= push_data_i;
   end

endmodule

// File: rtl/kt_pc_stack.sv
// Fetch-stage program counter: increment, relative/absolute jumps, stall and
// call/return via kt_ras. All outputs are registered or derived from registers.
module kt_pc_stack
   import kt_pc_pkg::*;
#(
   parameter int              ADDR_W     = 8,
   parameter int              OFS_W      = 5,
   parameter int              RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             stall_i,
   input  logic                             jump_rel_i,
   input  logic                             jump_abs_i,
   input  logic                             call_i,
   input  logic                             ret_i,
   input  logic [OFS_W-1:0]                 offset_i,
   input  logic [ADDR_W-1:0]                target_i,
   output logic [ADDR_W-1:0]                count_o,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   depth_o,
   output logic                             ras_full_o,
   output logic                             ras_empty_o,
   output logic                             ovf_err_o,
   output logic                             unf_err_o,
   output logic                             wrap_o
);

   pc_strb_t          strb;
   pc_op_e            op;
   logic [ADDR_W-1:0] count_q, count_d, ras_top;
   logic [ADDR_W:0]   inc_sum;
   logic [ADDR_W+1:0] rel_sum;
   logic              wrap_q, wrap_d, ovf_q, unf_q;
   logic              ras_ovf, ras_unf;

   assign strb = '{stall: stall_i, ret: ret_i, call: call_i, jabs: jump_abs_i, jrel: jump_rel_i};
   assign op   = decode_op(strb);

   // Two guard bits: any nonzero guard means the true result left 0..2^ADDR_W-1.
   assign inc_sum = {1'b0, count_q} + (ADDR_W+1)'(1);
   assign rel_sum = {2'b00, count_q} + (ADDR_W+2)'(sext64(64'(offset_i), OFS_W));

   kt_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (op == OP_CALL),
      .pop_i       (op == OP_RET),
      .push_data_i (inc_sum[ADDR_W-1:0]),
      .top_o       (ras_top),
      .depth_o     (depth_o),
      .full_o      (ras_full_o),
      .empty_o     (ras_empty_o),
      .ovf_o       (ras_ovf),
      .unf_o       (ras_unf)
   );

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      unique case (op)
         OP_HOLD: ;
         OP_RET: begin
            if (ras_empty_o) begin
               count_d = inc_sum[ADDR_W-1:0];
               wrap_d  = inc_sum[ADDR_W];
            end else begin
               count_d = ras_top;
            end
         end
         OP_CALL: begin
            count_d = target_i;
            wrap_d  = inc_sum[ADDR_W] && !ras_full_o;
         end
         OP_JABS: count_d = target_i;
         OP_JREL: begin
            count_d = rel_sum[ADDR_W-1:0];
            wrap_d  = |rel_sum[ADDR_W+1:ADDR_W];
         end
         default: begin
            count_d = inc_sum[ADDR_W-1:0];
            wrap_d  = inc_sum[ADDR_W];
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= RESET_ADDR;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_q | ras_ovf;
         unf_q   <= unf_q | ras_unf;
      end
   end

   assign count_o   = count_q;
   assign wrap_o    = wrap_q;
   assign ovf_err_o = ovf_q;
   assign unf_err_o = unf_q;

endmodule

// File: tb/tb_kt_pc_stack.sv
// Directed plan plus random strobes against an integer/queue model of the PC and stack.
module tb_kt_pc_stack;

   localparam int ADDR_W = 8, OFS_W = 5, RAS_DEPTH = 4, DW = $clog2(RAS_DEPTH + 1);
   localparam int M = 1 << ADDR_W;

   logic              clk_i = 0, rst_i = 1;
   logic              stall_i = 0, jump_rel_i = 0, jump_abs_i = 0, call_i = 0, ret_i = 0;
   logic [OFS_W-1:0]  offset_i = '0;
   logic [ADDR_W-1:0] target_i = '0;
   logic [ADDR_W-1:0] count_o;
   logic [DW-1:0]     depth_o;
   logic              ras_full_o, ras_empty_o, ovf_err_o, unf_err_o, wrap_o;

   kt_pc_stack #(.ADDR_W(ADDR_W), .OFS_W(OFS_W), .RAS_DEPTH(RAS_DEPTH), .RESET_ADDR('0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .jump_rel_i(jump_rel_i),
      .jump_abs_i(jump_abs_i), .call_i(call_i), .ret_i(ret_i), .offset_i(offset_i),
      .target_i(target_i), .count_o(count_o), .depth_o(depth_o), .ras_full_o(ras_full_o),
      .ras_empty_o(ras_empty_o), .ovf_err_o(ovf_err_o), .unf_err_o(unf_err_o), .wrap_o(wrap_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, failures = 0;
   bit run = 0;

   // Model state
   int m_pc;
   int stk[$];
   bit m_ovf, m_unf, m_wrap;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; stk.delete(); m_ovf = 0; m_unf = 0; m_wrap = 0;
   endtask

   task automatic model_step();
      int nx, o;
      if (rst_i) begin model_reset(); return; end
      m_wrap = 0;
      if (stall_i) begin
      end else if (ret_i) begin
         if (stk.size() > 0) m_pc = stk.pop_back();
         else begin nx = m_pc + 1; m_wrap = nx >= M; m_pc = nx % M; m_unf = 1; end
      end else if (call_i) begin
         if (stk.size() < RAS_DEPTH) begin
            nx = m_pc + 1; m_wrap = nx >= M; stk.push_back(nx % M);
         end else m_ovf = 1;
         m_pc = int'(target_i);
      end else if (jump_abs_i) begin
         m_pc = int'(target_i);
      end else if (jump_rel_i) begin
         o = int'(offset_i);
         if (o >= (1 << (OFS_W - 1))) o -= (1 << OFS_W);
         nx = m_pc + o; m_wrap = (nx < 0) || (nx >= M); m_pc = (nx + M) % M;
      end else begin
         nx = m_pc + 1; m_wrap = nx >= M; m_pc = nx % M;
      end
   endtask

   // Advance one clock; model consumes the inputs the DUT just sampled.
   task automatic tick();
      @(posedge clk_i); #1;
      model_step();
   endtask

   task automatic drive(input bit st, input bit rt, input bit cl, input bit ja, input bit jr,
                        input int ofs, input int tgt);
      stall_i = st; ret_i = rt; call_i = cl; jump_abs_i = ja; jump_rel_i = jr;
      offset_i = OFS_W'(ofs); target_i = ADDR_W'(tgt);
   endtask

   task automatic op(input bit st, input bit rt, input bit cl, input bit ja, input bit jr,
                     input int ofs, input int tgt);
      drive(st, rt, cl, ja, jr, ofs, tgt);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk_i) begin
      if (run && !rst_i) begin
         chk("count", int'(count_o), m_pc);
         chk("depth", int'(depth_o), stk.size());
         chk("full", int'(ras_full_o), int'(stk.size() == RAS_DEPTH));
         chk("empty", int'(ras_empty_o), int'(stk.size() == 0));
         chk("ovf", int'(ovf_err_o), int'(m_ovf));
         chk("unf", int'(unf_err_o), int'(m_unf));
         chk("wrap", int'(wrap_o), int'(m_wrap));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_count", int'(count_o), 0);
      chk("rst_depth", int'(depth_o), 0);
      chk("rst_empty", int'(ras_empty_o), 1);
      chk("rst_full", int'(ras_full_o), 0);
      chk("rst_flags", int'({ovf_err_o, unf_err_o, wrap_o}), 0);
      rst_i = 0;
      run = 1;

      // 1: free-running count and wrap at 255 -> 0
      for (int i = 1; i <= 260; i++) begin
         tick();
         if (i == 255) chk("t1_ff", int'(count_o), 8'hFF);
         if (i == 256) begin chk("t1_zero", int'(count_o), 0); chk("t1_wrap", int'(wrap_o), 1); end
         if (i == 257) chk("t1_nowrap", int'(wrap_o), 0);
      end
      rst_i = 1; #1;
      chk("t1_async_rst", int'(count_o), 0);
      model_reset();
      tick(); rst_i = 0;

      // 2: relative jumps
      op(0, 0, 0, 1, 0, 0, 8'h10);
      op(0, 0, 0, 0, 1, 5'b10000, 0);
      chk("t2_m16", int'(count_o), 0); chk("t2_m16_wrap", int'(wrap_o), 0);
      op(0, 0, 0, 0, 1, 5'b11111, 0);
      chk("t2_m1", int'(count_o), 8'hFF); chk("t2_m1_wrap", int'(wrap_o), 1);
      op(0, 0, 0, 0, 1, 15, 0);
      chk("t2_p15", int'(count_o), 8'h0E); chk("t2_p15_wrap", int'(wrap_o), 1);
      op(0, 0, 0, 0, 1, 0, 0);
      chk("t2_self", int'(count_o), 8'h0E);

      // 3: nested calls
      op(0, 0, 0, 1, 0, 0, 8'h20);
      op(0, 0, 1, 0, 0, 0, 8'h40); chk("t3_c1", int'(count_o), 8'h40); chk("t3_d1", int'(depth_o), 1);
      op(0, 0, 1, 0, 0, 0, 8'h60); chk("t3_c2", int'(count_o), 8'h60); chk("t3_d2", int'(depth_o), 2);
      op(0, 1, 0, 0, 0, 0, 0);     chk("t3_r1", int'(count_o), 8'h41); chk("t3_d3", int'(depth_o), 1);
      op(0, 1, 0, 0, 0, 0, 0);     chk("t3_r2", int'(count_o), 8'h21); chk("t3_d4", int'(depth_o), 0);
      chk("t3_empty", int'(ras_empty_o), 1);

      // 4: overflow / underflow
      for (int i = 0; i < 5; i++) begin
         op(0, 0, 1, 0, 0, 0, 8'h80 + i);
         if (i == 3) begin chk("t4_full", int'(ras_full_o), 1); chk("t4_noovf", int'(ovf_err_o), 0); end
      end
      chk("t4_jump", int'(count_o), 8'h84); chk("t4_ovf", int'(ovf_err_o), 1);
      op(0, 1, 0, 0, 0, 0, 0); chk("t4_r1", int'(count_o), 8'h83);
      repeat (3) op(0, 1, 0, 0, 0, 0, 0);
      chk("t4_r4", int'(count_o), 8'h22);
      op(0, 1, 0, 0, 0, 0, 0);
      chk("t4_r5", int'(count_o), 8'h23); chk("t4_unf", int'(unf_err_o), 1);
      repeat (5) tick();
      chk("t4_sticky", int'({ovf_err_o, unf_err_o}), 3);

      // 5: simultaneous strobes
      op(0, 0, 0, 1, 0, 0, 8'h50);
      op(0, 0, 1, 0, 0, 0, 8'h70);
      op(0, 0, 1, 0, 0, 0, 8'h90);
      op(0, 1, 1, 1, 1, 3, 8'hC0); chk("t5_pop", int'(count_o), 8'h71); chk("t5_pd", int'(depth_o), 1);
      op(0, 0, 1, 0, 1, 3, 8'hA0); chk("t5_call", int'(count_o), 8'hA0); chk("t5_cd", int'(depth_o), 2);
      op(1, 1, 1, 1, 1, 3, 8'hC0); chk("t5_stall", int'(count_o), 8'hA0); chk("t5_sw", int'(wrap_o), 0);

      // 6: call from all-ones pushes 0 with wrap
      op(0, 0, 0, 1, 0, 0, 8'hFF);
      op(0, 0, 1, 0, 0, 0, 8'h30); chk("t6_call", int'(count_o), 8'h30); chk("t6_wrap", int'(wrap_o), 1);
      op(0, 1, 0, 0, 0, 0, 0);     chk("t6_ret", int'(count_o), 0); chk("t6_nowrap", int'(wrap_o), 0);

      // Random strobes with occasional reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_i = 1; #1;
            chk("rnd_async_rst", int'(count_o), 0);
            model_reset();
            tick(); rst_i = 0;
         end else begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, (1 << OFS_W) - 1)), int'($urandom_range(0, M - 1)));
            tick();
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      @(negedge clk_i); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
